// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and constants for the matmul process unit
//
// Purpose: state codes for the phase sequencer and the operand-B base offset helper.
// Ports:   none (package).
package matmul_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD    = 3'd1;
  localparam state_t S_COMPUTE = 3'd2;
  localparam state_t S_DRAIN   = 3'd3;
  localparam state_t S_STORE   = 3'd4;
  localparam state_t S_DONE    = 3'd5;

  // Operand B occupies the slots directly after the N*N slots of A.
  function automatic int b_base(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// rtl/matmul_index_counter.sv - nested i/j/k counter with enable, clear and last flag
//
// Purpose: counts k innermost, then j, then i, each wrapping at its limit.
//          Tie i_lim_j and i_lim_k to 1 to get a plain linear counter on o_i.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_clr                 zero all indices on the next edge (wins over i_en)
//   i_en                  advance one step on the next edge
//   i_lim_i/j/k           iteration counts per dimension (each >= 1)
//   o_i, o_j, o_k         current indices
//   o_i_nx, o_j_nx, o_k_nx  values the indices take on the next edge
//   o_last                current indices are the final iteration
module matmul_index_counter #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_lim_i,
  input  logic [W-1:0] i_lim_j,
  input  logic [W-1:0] i_lim_k,
  output logic [W-1:0] o_i,
  output logic [W-1:0] o_j,
  output logic [W-1:0] o_k,
  output logic [W-1:0] o_i_nx,
  output logic [W-1:0] o_j_nx,
  output logic [W-1:0] o_k_nx,
  output logic         o_last
);

  logic [W-1:0] r_i, r_j, r_k;
  logic         w_i_last, w_j_last, w_k_last;

  assign w_i_last = (r_i == i_lim_i - W'(1));
  assign w_j_last = (r_j == i_lim_j - W'(1));
  assign w_k_last = (r_k == i_lim_k - W'(1));
  assign o_last   = w_i_last && w_j_last && w_k_last;

  always_comb begin
    o_i_nx = r_i;
    o_j_nx = r_j;
    o_k_nx = r_k;
    if (i_clr) begin
      o_i_nx = '0;
      o_j_nx = '0;
      o_k_nx = '0;
    end else if (i_en) begin
      if (!w_k_last) begin
        o_k_nx = r_k + W'(1);
      end else begin
        o_k_nx = '0;
        if (!w_j_last) begin
          o_j_nx = r_j + W'(1);
        end else begin
          o_j_nx = '0;
          o_i_nx = w_i_last ? '0 : r_i + W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else begin
      r_i <= o_i_nx;
      r_j <= o_j_nx;
      r_k <= o_k_nx;
    end
  end

  assign o_i = r_i;
  assign o_j = r_j;
  assign o_k = r_k;

endmodule

// File: rtl/matmul_process_unit.sv
// rtl/matmul_process_unit.sv - load/compute/store sequencer for C = A x B (N x N)
//
// Purpose: runs the phase granted by the state controller and reports completion.
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   g1, g2, g3            load / compute / store grants
//   process_ready         pulse: load or store finished
//   process_finish        pulse: compute finished
//   busy, err             phase executing / sticky multiple-grant error
//   mem_addr, mem_wr, mem_rd   operand write (load) and result read (store) port
//   addr_a, addr_b        compute operand addresses (combinational)
//   mac_en, mac_clear     MAC step / start new accumulation
//   res_wr, res_addr      write finished dot product to result slot
module matmul_process_unit #(
  parameter int N          = 3,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  g1,
  input  logic                  g2,
  input  logic                  g3,
  output logic                  process_ready,
  output logic                  process_finish,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  mac_en,
  output logic                  mac_clear,
  output logic                  res_wr,
  output logic [ADDR_WIDTH-1:0] res_addr
);
  import matmul_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] W_N   = AW'(N);
  localparam logic [AW-1:0] W_NN  = AW'(N * N);
  localparam logic [AW-1:0] W_NN2 = AW'(2 * N * N);
  localparam logic [AW-1:0] W_BB  = AW'(b_base(N));

  state_t r_state, w_state_n;
  logic [1:0] w_gcnt;

  logic          w_cnt_clr, w_lin_en, w_mm_en;
  logic [AW-1:0] w_lin_lim;
  logic [AW-1:0] w_lin_i, w_lin_j, w_lin_k, w_lin_i_nx, w_lin_j_nx, w_lin_k_nx;
  logic          w_lin_last;
  logic [AW-1:0] w_mm_i, w_mm_j, w_mm_k, w_mm_i_nx, w_mm_j_nx, w_mm_k_nx;
  logic          w_mm_last;
  logic          w_unused_cnt;

  logic          w_ready_d, w_finish_d, w_busy_d, w_err_d;
  logic          w_mem_wr_d, w_mem_rd_d, w_mac_en_d, w_mac_clear_d, w_res_wr_d;
  logic [AW-1:0] w_mem_addr_d, w_res_addr_d;

  logic          r_ready, r_finish, r_busy, r_err;
  logic          r_mem_wr, r_mem_rd, r_mac_en, r_mac_clear, r_res_wr;
  logic [AW-1:0] r_mem_addr, r_res_addr;

  assign w_gcnt = 2'(g1) + 2'(g2) + 2'(g3);

  // Counters start from zero on every state change and step only while a phase continues.
  assign w_cnt_clr = (w_state_n != r_state);
  assign w_lin_en  = !w_cnt_clr && (r_state == S_LOAD || r_state == S_STORE);
  assign w_mm_en   = !w_cnt_clr && (r_state == S_COMPUTE);
  assign w_lin_lim = (r_state == S_STORE) ? W_NN : W_NN2;

  matmul_index_counter #(.W(AW)) u_lin_cnt (
    .i_clk(clock), .i_rst(reset), .i_clr(w_cnt_clr), .i_en(w_lin_en),
    .i_lim_i(w_lin_lim), .i_lim_j(AW'(1)), .i_lim_k(AW'(1)),
    .o_i(w_lin_i), .o_j(w_lin_j), .o_k(w_lin_k),
    .o_i_nx(w_lin_i_nx), .o_j_nx(w_lin_j_nx), .o_k_nx(w_lin_k_nx),
    .o_last(w_lin_last)
  );

  matmul_index_counter #(.W(AW)) u_mm_cnt (
    .i_clk(clock), .i_rst(reset), .i_clr(w_cnt_clr), .i_en(w_mm_en),
    .i_lim_i(W_N), .i_lim_j(W_N), .i_lim_k(W_N),
    .o_i(w_mm_i), .o_j(w_mm_j), .o_k(w_mm_k),
    .o_i_nx(w_mm_i_nx), .o_j_nx(w_mm_j_nx), .o_k_nx(w_mm_k_nx),
    .o_last(w_mm_last)
  );

  assign w_unused_cnt = ^{w_lin_i, w_lin_j, w_lin_k, w_lin_j_nx, w_lin_k_nx,
                          w_mm_i_nx, w_mm_j_nx};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gcnt == 2'd1) w_state_n = g1 ? S_LOAD : (g2 ? S_COMPUTE : S_STORE);
      end
      S_LOAD: begin
        if (!g1)             w_state_n = S_IDLE;
        else if (w_lin_last) w_state_n = S_DONE;
      end
      S_COMPUTE: begin
        if (!g2)            w_state_n = S_IDLE;
        else if (w_mm_last) w_state_n = S_DRAIN;
      end
      S_DRAIN: w_state_n = S_DONE;
      S_STORE: begin
        if (!g3)             w_state_n = S_IDLE;
        else if (w_lin_last) w_state_n = S_DONE;
      end
      S_DONE: begin
        if (w_gcnt == 2'd0) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Next-cycle output values, derived from the upcoming state and counter values
  // so every output below is a flop that lines up with the state it describes.
  always_comb begin
    w_busy_d      = (w_state_n == S_LOAD) || (w_state_n == S_COMPUTE) ||
                    (w_state_n == S_DRAIN) || (w_state_n == S_STORE);
    w_mem_wr_d    = (w_state_n == S_LOAD);
    w_mem_rd_d    = (w_state_n == S_STORE);
    w_mem_addr_d  = (w_mem_wr_d || w_mem_rd_d) ? w_lin_i_nx : '0;
    w_mac_en_d    = (w_state_n == S_COMPUTE);
    w_mac_clear_d = w_mac_en_d && (w_mm_k_nx == '0);
    // A dot product completes on its k==N-1 cycle; a withdrawn grant suppresses it.
    w_res_wr_d    = (r_state == S_COMPUTE) && (w_mm_k == W_N - AW'(1)) &&
                    (w_state_n != S_IDLE);
    w_res_addr_d  = w_res_wr_d ? (w_mm_i * W_N + w_mm_j) : '0;
    w_finish_d    = (w_state_n == S_DRAIN);
    w_ready_d     = (w_state_n == S_DONE) && (r_state == S_LOAD || r_state == S_STORE);
    w_err_d       = r_err || ((r_state == S_IDLE) && (w_gcnt >= 2'd2));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_finish    <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_mac_en    <= 1'b0;
      r_mac_clear <= 1'b0;
      r_res_wr    <= 1'b0;
      r_res_addr  <= '0;
    end else begin
      r_ready     <= w_ready_d;
      r_finish    <= w_finish_d;
      r_busy      <= w_busy_d;
      r_err       <= w_err_d;
      r_mem_wr    <= w_mem_wr_d;
      r_mem_rd    <= w_mem_rd_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mac_en    <= w_mac_en_d;
      r_mac_clear <= w_mac_clear_d;
      r_res_wr    <= w_res_wr_d;
      r_res_addr  <= w_res_addr_d;
    end
  end

  assign process_ready  = r_ready;
  assign process_finish = r_finish;
  assign busy           = r_busy;
  assign err            = r_err;
  assign mem_wr         = r_mem_wr;
  assign mem_rd         = r_mem_rd;
  assign mem_addr       = r_mem_addr;
  assign mac_en         = r_mac_en;
  assign mac_clear      = r_mac_clear;
  assign res_wr         = r_res_wr;
  assign res_addr       = r_res_addr;

  // Operand addresses follow the live counters; held at zero outside COMPUTE.
  assign addr_a = (r_state == S_COMPUTE) ? (w_mm_i * W_N + w_mm_k) : '0;
  assign addr_b = (r_state == S_COMPUTE) ? (W_BB + w_mm_k * W_N + w_mm_j) : '0;

endmodule

// File: tb/tb_matmul_process_unit.sv
// tb/tb_matmul_process_unit.sv - scoreboard bench for matmul_process_unit (N=2)
module tb_matmul_process_unit;

  localparam int TN = 2;
  localparam int AW = 5;

  logic clock, reset, g1, g2, g3;
  logic process_ready, process_finish, busy, err;
  logic [AW-1:0] mem_addr, addr_a, addr_b, res_addr;
  logic mem_wr, mem_rd, mac_en, mac_clear, res_wr;

  matmul_process_unit #(.N(TN), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .g1(g1), .g2(g2), .g3(g3),
    .process_ready(process_ready), .process_finish(process_finish),
    .busy(busy), .err(err), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .addr_a(addr_a), .addr_b(addr_b), .mac_en(mac_en), .mac_clear(mac_clear),
    .res_wr(res_wr), .res_addr(res_addr)
  );

  typedef struct packed {
    logic [7:0]    cyc;
    logic          wr, rd;
    logic [AW-1:0] maddr;
    logic          mac, clr;
    logic [AW-1:0] a, b;
    logic          rw;
    logic [AW-1:0] raddr;
    logic          rdy, fin;
  } ev_t;

  ev_t q[$];
  ev_t mon_o, mon_e;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;
  int  t0       = 0;
  bit  mon_en   = 0;
  logic [28:0] w_outs;

  assign w_outs = {process_ready, process_finish, busy, err, mem_addr, mem_wr, mem_rd,
                   addr_a, addr_b, mac_en, mac_clear, res_wr, res_addr};

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_linear(input int len, input bit is_wr);
    ev_t e;
    for (int c = 1; c <= len + 1; c++) begin
      e = '0;
      e.cyc = 8'(c);
      if (c <= len) begin
        e.wr    = is_wr;
        e.rd    = !is_wr;
        e.maddr = AW'(c - 1);
      end else begin
        e.rdy = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  task automatic push_compute(input int upto);
    ev_t e [0:127];
    for (int c = 0; c < 128; c++) e[c] = '0;
    for (int x = 0; x < TN * TN * TN; x++) begin
      int c, i, j, k;
      c = x + 1;
      k = x % TN;
      j = (x / TN) % TN;
      i = x / (TN * TN);
      e[c].mac = 1'b1;
      e[c].clr = (k == 0);
      e[c].a   = AW'(i * TN + k);
      e[c].b   = AW'(TN * TN + k * TN + j);
      if (k == TN - 1) begin
        e[c+1].rw    = 1'b1;
        e[c+1].raddr = AW'(i * TN + j);
      end
    end
    e[TN * TN * TN + 1].fin = 1'b1;
    for (int c = 1; c < 128; c++) begin
      if (c <= upto && e[c] != '0) begin
        e[c].cyc = 8'(c);
        q.push_back(e[c]);
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && (mem_wr || mem_rd || mac_en || res_wr || process_ready || process_finish)) begin
      mon_o       = '0;
      mon_o.cyc   = 8'(cyc - t0);
      mon_o.wr    = mem_wr;
      mon_o.rd    = mem_rd;
      mon_o.maddr = mem_addr;
      mon_o.mac   = mac_en;
      mon_o.clr   = mac_clear;
      mon_o.a     = addr_a;
      mon_o.b     = addr_b;
      mon_o.rw    = res_wr;
      mon_o.raddr = res_addr;
      mon_o.rdy   = process_ready;
      mon_o.fin   = process_finish;
      if (q.size() == 0) begin
        check("unexpected_event", 64'(mon_o), 64'(0));
      end else begin
        mon_e = q.pop_front();
        check("event", 64'(mon_o), 64'(mon_e));
      end
    end
  end

  initial begin
    reset = 1'b1; g1 = 1'b0; g2 = 1'b0; g3 = 1'b0;
    tick(2);
    check("reset_outputs", 64'(w_outs), 64'(0));
    reset = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Load: 2N^2 writes, ready once, no retrigger while g1 held
    push_linear(2 * TN * TN, 1'b1);
    t0 = cyc; g1 = 1'b1;
    tick(3);
    check("load_busy", 64'(busy), 64'(1));
    tick(9);
    check("load_busy_after", 64'(busy), 64'(0));
    check("load_queue_empty", 64'(q.size()), 64'(0));
    g1 = 1'b0;
    tick(2);

    // Full compute
    push_compute(100);
    t0 = cyc; g2 = 1'b1;
    tick(12);
    check("compute_queue_empty", 64'(q.size()), 64'(0));
    check("compute_busy_after", 64'(busy), 64'(0));
    g2 = 1'b0;
    tick(2);

    // Store: N^2 reads then ready
    push_linear(TN * TN, 1'b0);
    t0 = cyc; g3 = 1'b1;
    tick(8);
    check("store_queue_empty", 64'(q.size()), 64'(0));
    g3 = 1'b0;
    tick(2);

    // Grant withdrawn after four compute cycles, then a fresh compute
    push_compute(4);
    t0 = cyc; g2 = 1'b1;
    tick(4);
    g2 = 1'b0;
    tick(1);
    check("withdraw_busy", 64'(busy), 64'(0));
    tick(3);
    check("withdraw_queue_empty", 64'(q.size()), 64'(0));
    push_compute(100);
    t0 = cyc; g2 = 1'b1;
    tick(12);
    check("restart_queue_empty", 64'(q.size()), 64'(0));
    g2 = 1'b0;
    tick(2);

    // Two grants together: sticky error, nothing starts
    g1 = 1'b1; g2 = 1'b1;
    tick(3);
    check("dual_err", 64'(err), 64'(1));
    check("dual_busy", 64'(busy), 64'(0));
    g1 = 1'b0; g2 = 1'b0;
    tick(2);
    check("err_sticky", 64'(err), 64'(1));
    reset = 1'b1;
    tick(1);
    check("err_cleared", 64'(err), 64'(0));
    reset = 1'b0;
    tick(2);

    // Asynchronous reset in the middle of cycle 3 of a compute
    push_compute(3);
    t0 = cyc; g2 = 1'b1;
    tick(3);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_outputs", 64'(w_outs), 64'(0));
    check("reset_mid_queue_empty", 64'(q.size()), 64'(0));
    tick(2);
    reset = 1'b0;
    push_compute(100);
    t0 = cyc;
    tick(12);
    check("after_reset_queue_empty", 64'(q.size()), 64'(0));
    g2 = 1'b0;
    tick(3);
    check("final_queue_empty", 64'(q.size()), 64'(0));
    check("final_busy", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
